// File: rtl/nunchuck_pkg.sv
// Shared types and constants for the Nunchuck I2C target emulation.
package nunchuck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WR_BYTE,
        ST_ACK_WR,
        ST_RD_BYTE,
        ST_RD_MACK
    } state_t;

    localparam logic [6:0] NUNCHUCK_ADDR = 7'h52;
    localparam logic [7:0] REG_INIT1     = 8'hF0;
    localparam logic [7:0] REG_INIT2     = 8'hFB;
    localparam logic [7:0] INIT1_VAL     = 8'h55;
    localparam logic [7:0] INIT2_VAL     = 8'h00;
    localparam int         REPORT_BYTES  = 6;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clock domain and flags bus edges and START/STOP conditions.
module i2c_bus_monitor (
    input  logic clock,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Reset to the idle-bus level so no spurious START/STOP appears after reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/nunchuck_responder.sv
// I2C target emulating a Wii Nunchuck: init handshake, register pointer writes, 6-byte report reads.
module nunchuck_responder
    import nunchuck_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = NUNCHUCK_ADDR
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       SCLpin,
    inout  wire        SDApin,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic [9:0] accel_x,
    input  logic [9:0] accel_y,
    input  logic [9:0] accel_z,
    input  logic       z,
    input  logic       c,
    output logic       ready,
    output logic       busy,
    output logic [7:0] reads_served
);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_monitor u_mon (
        .clock    (clock),
        .rst      (rst),
        .scl      (SCLpin),
        .sda      (SDApin),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    state_t      state, state_nxt;
    logic        drive, drive_nxt;
    logic [3:0]  bit_cnt;
    logic [7:0]  ptr;
    logic [7:0]  cfg_init1, cfg_init2;
    logic        rd_mode, wr_first, mack, sent_last;
    logic [7:0]  rx_sr, tx_sr, tx_next;
    logic [7:0]  report [REPORT_BYTES];
    logic [7:0]  shadow [REPORT_BYTES];
    logic        addr_hit, byte_rx, load_tx, shift_tx, shift_rx, byte_tx_done, sample_mack;

    // Open-drain: only ever pull low.
    assign SDApin = drive ? 1'b0 : 1'bz;

    always_comb begin
        report[0] = stick_x;
        report[1] = stick_y;
        report[2] = accel_x[9:2];
        report[3] = accel_y[9:2];
        report[4] = accel_z[9:2];
        report[5] = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z};
    end

    always_comb begin
        tx_next = 8'h00;
        if (ptr < 8'(REPORT_BYTES))
            tx_next = ready ? shadow[ptr[2:0]] : 8'hFF;
        else if (ptr == REG_INIT1)
            tx_next = cfg_init1;
        else if (ptr == REG_INIT2)
            tx_next = cfg_init2;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // START/STOP take priority over any SCL edge seen in the same cycle.
    always_comb begin
        state_nxt    = state;
        drive_nxt    = drive;
        addr_hit     = 1'b0;
        byte_rx      = 1'b0;
        load_tx      = 1'b0;
        shift_tx     = 1'b0;
        byte_tx_done = 1'b0;
        sample_mack  = 1'b0;
        shift_rx     = 1'b0;
        if (start) begin
            state_nxt = ST_ADDR;
            drive_nxt = 1'b0;
        end else if (stop) begin
            state_nxt = ST_IDLE;
            drive_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ADDR: begin
                    shift_rx = scl_rise && (bit_cnt < 4'd8);
                    if (scl_fall && bit_cnt == 4'd8) begin
                        if (rx_sr[7:1] == DEVICE_ADDR) begin
                            state_nxt = ST_ACK_ADDR;
                            drive_nxt = 1'b1;
                            addr_hit  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            drive_nxt = 1'b0;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rd_mode) begin
                            state_nxt = ST_RD_BYTE;
                            load_tx   = 1'b1;
                            drive_nxt = ~tx_next[7];
                        end else begin
                            state_nxt = ST_WR_BYTE;
                            drive_nxt = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    shift_rx = scl_rise && (bit_cnt < 4'd8);
                    if (scl_fall && bit_cnt == 4'd8) begin
                        state_nxt = ST_ACK_WR;
                        drive_nxt = 1'b1;
                        byte_rx   = 1'b1;
                    end
                end
                ST_ACK_WR: begin
                    if (scl_fall) begin
                        state_nxt = ST_WR_BYTE;
                        drive_nxt = 1'b0;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_nxt    = ST_RD_MACK;
                            drive_nxt    = 1'b0;
                            byte_tx_done = 1'b1;
                        end else begin
                            shift_tx  = 1'b1;
                            drive_nxt = ~tx_sr[6];
                        end
                    end
                end
                ST_RD_MACK: begin
                    sample_mack = scl_rise;
                    if (scl_fall) begin
                        if (mack) begin
                            state_nxt = ST_RD_BYTE;
                            load_tx   = 1'b1;
                            drive_nxt = ~tx_next[7];
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            drive        <= 1'b0;
            bit_cnt      <= 4'd0;
            ptr          <= 8'h00;
            ready        <= 1'b0;
            busy         <= 1'b0;
            reads_served <= 8'h00;
            cfg_init1    <= 8'h00;
            cfg_init2    <= 8'h00;
            rd_mode      <= 1'b0;
            wr_first     <= 1'b0;
            mack         <= 1'b0;
            sent_last    <= 1'b0;
        end else begin
            drive <= drive_nxt;
            // Every state change starts a fresh bit count.
            if (start || state_nxt != state)
                bit_cnt <= 4'd0;
            else if (shift_rx || shift_tx)
                bit_cnt <= bit_cnt + 4'd1;
            if (stop)
                busy <= 1'b0;
            else if (addr_hit)
                busy <= 1'b1;
            if (addr_hit) begin
                rd_mode  <= rx_sr[0];
                wr_first <= 1'b1;
            end
            if (byte_rx) begin
                if (wr_first) begin
                    ptr      <= rx_sr;
                    wr_first <= 1'b0;
                end else begin
                    ptr <= ptr + 8'd1;
                    if (ptr == REG_INIT1) begin
                        cfg_init1 <= rx_sr;
                        if (rx_sr != INIT1_VAL) ready <= 1'b0;
                    end
                    if (ptr == REG_INIT2) begin
                        cfg_init2 <= rx_sr;
                        if (rx_sr == INIT2_VAL && cfg_init1 == INIT1_VAL) ready <= 1'b1;
                    end
                end
            end
            if (byte_tx_done) begin
                ptr       <= ptr + 8'd1;
                sent_last <= (ptr == 8'(REPORT_BYTES - 1));
            end
            if (sample_mack) begin
                mack <= ~sda_s;
                if (sent_last) reads_served <= reads_served + 8'd1;
            end
        end
    end

    // Datapath shift registers and report shadow carry no reset.
    always_ff @(posedge clock) begin
        if (shift_rx)
            rx_sr <= {rx_sr[6:0], sda_s};
        if (load_tx)
            tx_sr <= tx_next;
        else if (shift_tx)
            tx_sr <= {tx_sr[6:0], 1'b0};
        if (addr_hit && rx_sr[0])
            shadow <= report;
    end

endmodule

// File: tb/tb_nunchuck_responder.sv
// Bit-banged I2C initiator driving nunchuck_responder, checked against a transaction-level model.
module tb_nunchuck_responder;
    import nunchuck_pkg::*;

    localparam logic [6:0] DEV = 7'h52;

    logic       clock = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda_low;
    wire        sda;
    logic [7:0] stick_x, stick_y;
    logic [9:0] accel_x, accel_y, accel_z;
    logic       z, c;
    logic       ready, busy;
    logic [7:0] reads_served;

    int n_cmp = 0;
    int n_err = 0;

    int m_ptr, m_f0, m_fb, m_served;
    bit m_ready;
    logic [7:0] got [8];
    logic watch = 1'b0, saw_low = 1'b0, busy_seen = 1'b0;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    nunchuck_responder #(.DEVICE_ADDR(DEV)) dut (
        .clock        (clock),
        .rst          (rst),
        .SCLpin       (scl),
        .SDApin       (sda),
        .stick_x      (stick_x),
        .stick_y      (stick_y),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .z            (z),
        .c            (c),
        .ready        (ready),
        .busy         (busy),
        .reads_served (reads_served)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (watch) begin
            if (sda === 1'b0 && !m_sda_low) saw_low = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic q_wait;
        repeat (6) @(posedge clock);
        #2;
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b0; q_wait;
        scl = 1'b1;       q_wait;
        m_sda_low = 1'b1; q_wait;
        scl = 1'b0;       q_wait;
    endtask

    task automatic i2c_stop;
        m_sda_low = 1'b1; q_wait;
        scl = 1'b1;       q_wait;
        m_sda_low = 1'b0; q_wait;
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b; q_wait;
        scl = 1'b1;     q_wait; q_wait;
        scl = 1'b0;     q_wait;
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0; q_wait;
        scl = 1'b1;       q_wait;
        b = sda;          q_wait;
        scl = 1'b0;       q_wait;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
        acked = ~a;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            get_bit(v);
            b[i] = v;
        end
        put_bit(~ack);
    endtask

    function automatic int report_byte(input int idx);
        case (idx)
            0: return int'(stick_x);
            1: return int'(stick_y);
            2: return int'(accel_x) / 4;
            3: return int'(accel_y) / 4;
            4: return int'(accel_z) / 4;
            default: return (int'(accel_z) % 4) * 64 + (int'(accel_y) % 4) * 16
                          + (int'(accel_x) % 4) * 4 + (c ? 0 : 2) + (z ? 0 : 1);
        endcase
    endfunction

    task automatic model_store(input int v);
        if (m_ptr == 'hF0) begin
            m_f0 = v;
            if (v != 'h55) m_ready = 1'b0;
        end else if (m_ptr == 'hFB) begin
            m_fb = v;
            if (v == 0 && m_f0 == 'h55) m_ready = 1'b1;
        end
        m_ptr = (m_ptr + 1) % 256;
    endtask

    task automatic model_fetch(output int v);
        if (m_ptr < 6)         v = m_ready ? report_byte(m_ptr) : 'hFF;
        else if (m_ptr == 'hF0) v = m_f0;
        else if (m_ptr == 'hFB) v = m_fb;
        else                    v = 0;
        if (m_ptr == 5) m_served = (m_served + 1) % 256;
        m_ptr = (m_ptr + 1) % 256;
    endtask

    task automatic model_reset;
        m_ptr = 0; m_f0 = 0; m_fb = 0; m_served = 0; m_ready = 1'b0;
    endtask

    task automatic txn_write(input logic [7:0] p, input logic [7:0] v);
        logic a;
        i2c_start;
        write_byte({DEV, 1'b0}, a); check("wr_addr_ack", int'(a), 1);
        write_byte(p, a);           check("wr_ptr_ack", int'(a), 1);
        write_byte(v, a);           check("wr_data_ack", int'(a), 1);
        i2c_stop;
        m_ptr = int'(p);
        model_store(int'(v));
    endtask

    task automatic txn_read(input logic [7:0] p, input int n, input bit rep);
        logic a;
        logic [7:0] b;
        int exp;
        i2c_start;
        write_byte({DEV, 1'b0}, a); check("rd_wr_addr_ack", int'(a), 1);
        write_byte(p, a);           check("rd_ptr_ack", int'(a), 1);
        if (!rep) i2c_stop;
        m_ptr = int'(p);
        i2c_start;
        write_byte({DEV, 1'b1}, a); check("rd_addr_ack", int'(a), 1);
        check("busy_mid", int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i != n - 1);
            if (i < 8) got[i] = b;
            model_fetch(exp);
            check("rd_byte", int'(b), exp);
        end
        i2c_stop;
        check("busy_after_stop", int'(busy), 0);
        check("reads_served", int'(reads_served), m_served);
    endtask

    initial begin
        logic a;
        logic [7:0] addr_r;
        logic [7:0] fixed_exp [6];
        int op, sel, n;
        logic [7:0] p;

        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
        stick_x = 8'h00; stick_y = 8'h00;
        accel_x = 10'h000; accel_y = 10'h000; accel_z = 10'h000;
        z = 1'b0; c = 1'b0;
        model_reset;
        repeat (5) @(posedge clock);
        #2;
        check("reset_ready", int'(ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_served", int'(reads_served), 0);
        check("reset_sda", int'(sda), 1);
        rst = 1'b0;
        q_wait;

        // Not yet initialised: report reads all 0xFF.
        stick_x = 8'h12; accel_z = 10'h3C7;
        txn_read(8'h00, 6, 1'b0);
        for (int i = 0; i < 6; i++) check("uninit_ff", int'(got[i]), 'hFF);
        check("served_first", int'(reads_served), 1);

        // Init handshake.
        txn_write(REG_INIT1, INIT1_VAL);
        check("ready_after_f0", int'(ready), 0);
        txn_write(REG_INIT2, INIT2_VAL);
        check("ready_after_fb", int'(ready), 1);

        // Fixed report pattern.
        stick_x = 8'h80; stick_y = 8'h7F;
        accel_x = 10'h201; accel_y = 10'h3FE; accel_z = 10'h155;
        z = 1'b1; c = 1'b0;
        txn_read(8'h00, 6, 1'b1);
        fixed_exp = '{8'h80, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) check("fixed_report", int'(got[i]), int'(fixed_exp[i]));

        // Wrong address and general call are ignored.
        saw_low = 1'b0; busy_seen = 1'b0; watch = 1'b1;
        i2c_start;
        write_byte({7'h53, 1'b0}, a); check("addr53_nack", int'(a), 0);
        write_byte(8'hFF, a);         check("addr53_data_nack", int'(a), 0);
        i2c_stop;
        i2c_start;
        write_byte(8'h00, a);         check("gencall_nack", int'(a), 0);
        i2c_stop;
        watch = 1'b0;
        check("foreign_sda_low", int'(saw_low), 0);
        check("foreign_busy", int'(busy_seen), 0);

        // Pointer 0x04 with repeated START runs past the report.
        txn_read(8'h04, 3, 1'b1);
        check("ptr6_zero", int'(got[2]), 0);
        check("ptr4_accz", int'(got[0]), 'h55);

        // Pointer wrap 0xFE -> 0xFF -> 0x00.
        txn_read(8'hFE, 3, 1'b1);

        for (int it = 0; it < 10; it++) begin
            stick_x = 8'($urandom); stick_y = 8'($urandom);
            accel_x = 10'($urandom); accel_y = 10'($urandom); accel_z = 10'($urandom);
            z = 1'($urandom); c = 1'($urandom);
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                txn_write(REG_INIT1, INIT1_VAL);
                txn_write(REG_INIT2, INIT2_VAL);
            end else if (op == 1) begin
                txn_write(REG_INIT1, 8'($urandom_range(8'h54, 8'h56)));
            end else if (op == 2) begin
                txn_write(REG_INIT2, 8'($urandom_range(0, 1)));
            end else begin
                txn_write(8'($urandom), 8'($urandom));
            end
            check("rand_ready", int'(ready), int'(m_ready));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       p = 8'($urandom_range(0, 5));
                1:       p = REG_INIT1;
                2:       p = REG_INIT2;
                default: p = 8'($urandom);
            endcase
            n = int'($urandom_range(1, 4));
            txn_read(p, n, 1'($urandom));
        end

        // Reset during the address ACK of a read.
        txn_write(REG_INIT1, INIT1_VAL);
        txn_write(REG_INIT2, INIT2_VAL);
        addr_r = {DEV, 1'b1};
        i2c_start;
        for (int i = 7; i >= 0; i--) put_bit(addr_r[i]);
        m_sda_low = 1'b0; q_wait;
        scl = 1'b1;       q_wait;
        check("rst_ack_low", int'(sda), 0);
        rst = 1'b1;
        #1;
        check("rst_sda_release", int'(sda), 1);
        q_wait;
        rst = 1'b0;
        model_reset;
        check("rst_ready", int'(ready), 0);
        check("rst_served", int'(reads_served), 0);
        check("rst_busy", int'(busy), 0);
        scl = 1'b0; q_wait;
        i2c_stop;
        txn_read(8'h00, 2, 1'b0);
        check("post_rst_ff", int'(got[0]), 'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
